// File: rtl/mar_pkg.sv
// Shared types and constants for the MAR fetch unit.
package mar_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  localparam int DEF_DATA_WIDTH   = 32'sd8;
  localparam int DEF_ADDR_WIDTH   = 32'sd8;
  localparam int MAX_READ_LATENCY = 32'sd8;
  // Counts the extra edges after acceptance (at most MAX_READ_LATENCY-2).
  localparam int LAT_CNT_W        = $clog2(MAX_READ_LATENCY);

endpackage

// File: rtl/mar_ram.sv
// Word-addressed memory: one write port and one registered read port.
// A read and a write to the same address on the same edge return the old word.
module mar_ram
  import mar_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Memory array: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read-port next value: capture only on an enabled read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Read-port register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mar_fetch.sv
// MAR fetch unit: holds the address register, sequences reads through mar_ram
// with a configurable latency and presents registered results.
module mar_fetch
  import mar_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int READ_LATENCY = 32'sd1,
  parameter bit AUTO_INC     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  addr_load,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic                  addr_inc,
  input  logic                  rd_req,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] mar,
  output logic                  busy,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam bit MULTI_CYCLE = (READ_LATENCY > 32'sd1);
  localparam logic [LAT_CNT_W-1:0] WAIT_INIT =
    LAT_CNT_W'(MULTI_CYCLE ? (READ_LATENCY - 32'sd2) : 32'sd0);

  fetch_state_e          state_q, state_d;
  logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic                  busy_q, busy_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] ram_rdata_s;
  logic                  accept_s;

  assign accept_s = rd_req & ~busy_q;

  mar_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en  (accept_s),
    .rd_addr(mar_q),
    .rd_data(ram_rdata_s)
  );

  // FSM state and latency counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {LAT_CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: WAIT spans the READ_LATENCY-1 edges after acceptance.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept_s && MULTI_CYCLE) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {LAT_CNT_W{1'b0}}) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {LAT_CNT_W{1'b0}};
      end
    endcase
  end

  // FSM outputs, MAR update and result capture.
  always_comb begin
    busy_d     = (state_d == WAIT);
    cap_addr_d = cap_addr_q;
    rd_data_d  = rd_data_q;
    rd_addr_d  = rd_addr_q;
    mar_d      = mar_q;
    if (MULTI_CYCLE) begin
      rd_valid_d = (state_q == WAIT) && (cnt_q == {LAT_CNT_W{1'b0}});
    end else begin
      rd_valid_d = accept_s;
    end
    if (accept_s) begin
      cap_addr_d = mar_q;
    end else begin
      cap_addr_d = cap_addr_q;
    end
    // Single-cycle reads take the address straight from the MAR on acceptance.
    if (rd_valid_d) begin
      rd_data_d = ram_rdata_s;
      rd_addr_d = MULTI_CYCLE ? cap_addr_q : mar_q;
    end else begin
      rd_data_d = rd_data_q;
      rd_addr_d = rd_addr_q;
    end
    if (addr_load) begin
      mar_d = addr_in;
    end else if (addr_inc || (AUTO_INC && accept_s)) begin
      mar_d = mar_q + ADDR_WIDTH'(1'b1);
    end else begin
      mar_d = mar_q;
    end
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar_q      <= {ADDR_WIDTH{1'b0}};
      cap_addr_q <= {ADDR_WIDTH{1'b0}};
      busy_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_WIDTH{1'b0}};
      rd_addr_q  <= {ADDR_WIDTH{1'b0}};
    end else begin
      mar_q      <= mar_d;
      cap_addr_q <= cap_addr_d;
      busy_q     <= busy_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // With one-cycle latency the RAM read register already is the result register.
  assign rd_data  = MULTI_CYCLE ? rd_data_q : ram_rdata_s;
  assign mar      = mar_q;
  assign busy     = busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_mar_fetch.sv
// Bench for mar_fetch: three configurations share one stimulus stream and are
// checked every cycle against a transaction-level model plus literal expectations.
module tb_mar_fetch;

  localparam int NI = 3;  // 0: L=1 auto-inc, 1: L=3, 2: L=4

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       addr_load = 1'b0;
  logic [7:0] addr_in = 8'h00;
  logic       addr_inc = 1'b0;
  logic       rd_req = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;

  logic [7:0] o_mar [NI];
  logic       o_busy [NI];
  logic       o_rd_valid [NI];
  logic [7:0] o_rd_data [NI];
  logic [7:0] o_rd_addr [NI];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mar_fetch #(
      .DATA_WIDTH  (8),
      .ADDR_WIDTH  (8),
      .READ_LATENCY((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
      .AUTO_INC    (g == 0)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .addr_load(addr_load),
      .addr_in  (addr_in),
      .addr_inc (addr_inc),
      .rd_req   (rd_req),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .mar      (o_mar[g]),
      .busy     (o_busy[g]),
      .rd_valid (o_rd_valid[g]),
      .rd_data  (o_rd_data[g]),
      .rd_addr  (o_rd_addr[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic bit ai_of(input int k);
    return (k == 0);
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[dut%0d] at %0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Model: every read is a transaction with an issue edge and a due edge.
  int unsigned edge_n = 0;
  logic [7:0]  m_mem [256];
  logic [7:0]  m_mar [NI];
  int unsigned m_next_ok [NI];
  bit          m_pend [NI];
  int unsigned m_due [NI];
  logic [7:0]  m_pdata [NI];
  logic [7:0]  m_paddr [NI];
  bit          e_valid [NI];
  bit          e_busy [NI];
  logic [7:0]  e_data [NI];
  logic [7:0]  e_addr [NI];

  always @(posedge clk or posedge rst) begin
    bit acc;
    if (rst) begin
      for (int k = 0; k < NI; k++) begin
        m_mar[k] = 8'h00; m_next_ok[k] = 0; m_pend[k] = 1'b0; m_due[k] = 0;
        e_valid[k] = 1'b0; e_busy[k] = 1'b0; e_data[k] = 8'h00; e_addr[k] = 8'h00;
      end
    end else begin
      for (int k = 0; k < NI; k++) begin
        acc = rd_req && (edge_n >= m_next_ok[k]);
        if (acc) begin
          m_pend[k]    = 1'b1;
          m_due[k]     = edge_n + lat_of(k) - 1;
          m_next_ok[k] = edge_n + lat_of(k);
          m_pdata[k]   = m_mem[m_mar[k]];
          m_paddr[k]   = m_mar[k];
        end
        if (addr_load) m_mar[k] = addr_in;
        else if (addr_inc || (acc && ai_of(k))) m_mar[k] = m_mar[k] + 8'd1;
        e_valid[k] = m_pend[k] && (m_due[k] == edge_n);
        if (e_valid[k]) begin
          e_data[k] = m_pdata[k];
          e_addr[k] = m_paddr[k];
          m_pend[k] = 1'b0;
        end
        e_busy[k] = (edge_n + 1 < m_next_ok[k]);
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
      edge_n++;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      check("mar", k, 32'(o_mar[k]), 32'(m_mar[k]));
      check("busy", k, 32'(o_busy[k]), 32'(e_busy[k]));
      check("rd_valid", k, 32'(o_rd_valid[k]), 32'(e_valid[k]));
      check("rd_data", k, 32'(o_rd_data[k]), 32'(e_data[k]));
      check("rd_addr", k, 32'(o_rd_addr[k]), 32'(e_addr[k]));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] init_v [5] = '{8'h01, 8'h04, 8'h10, 8'h80, 8'h20};
  int         vcount;

  initial begin
    cyc(2);
    for (int k = 0; k < NI; k++) begin
      check("reset_mar", k, 32'(o_mar[k]), 32'h0);
      check("reset_valid", k, 32'(o_rd_valid[k]), 32'h0);
    end
    rst = 1'b0;

    // Preload every word so any MAR value reads defined data.
    wr_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      wr_addr = 8'(i);
      wr_data = (i < 5) ? init_v[i] : (8'(i) ^ 8'h5A);
      cyc();
    end
    wr_en = 1'b0;

    // Back-to-back single-cycle reads with auto-increment.
    rd_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("stream_valid", 0, 32'(o_rd_valid[0]), 32'h1);
      check("stream_data", 0, 32'(o_rd_data[0]), 32'(init_v[k]));
      check("stream_addr", 0, 32'(o_rd_addr[0]), 32'(k));
    end
    rd_req = 1'b0;
    cyc();
    check("stream_mar", 0, 32'(o_mar[0]), 32'h5);
    check("stream_hold", 0, 32'(o_rd_data[0]), 32'h20);
    cyc(5);

    // Three-cycle read; the request during busy must be dropped.
    addr_load = 1'b1; addr_in = 8'h02;
    cyc();
    addr_load = 1'b0; rd_req = 1'b1;
    cyc();
    check("l3_busy0", 1, 32'(o_busy[1]), 32'h1);
    cyc();
    check("l3_busy1", 1, 32'(o_busy[1]), 32'h1);
    check("l3_novalid", 1, 32'(o_rd_valid[1]), 32'h0);
    rd_req = 1'b0;
    cyc();
    check("l3_valid", 1, 32'(o_rd_valid[1]), 32'h1);
    check("l3_data", 1, 32'(o_rd_data[1]), 32'h10);
    check("l3_addr", 1, 32'(o_rd_addr[1]), 32'h02);
    check("l3_idle", 1, 32'(o_busy[1]), 32'h0);
    cyc(2);
    check("l3_noqueue", 1, 32'(o_rd_valid[1]), 32'h0);
    cyc(4);

    // MAR wrap and load-over-increment priority.
    addr_load = 1'b1; addr_in = 8'hFF;
    cyc();
    check("load_ff", 1, 32'(o_mar[1]), 32'hFF);
    addr_load = 1'b0; addr_inc = 1'b1;
    cyc();
    check("inc_wrap", 1, 32'(o_mar[1]), 32'h00);
    addr_load = 1'b1; addr_in = 8'h37;
    cyc();
    check("load_prio", 2, 32'(o_mar[2]), 32'h37);
    addr_load = 1'b0; addr_inc = 1'b0;

    // Read-before-write on the acceptance edge.
    addr_load = 1'b1; addr_in = 8'h03;
    cyc();
    addr_load = 1'b0; rd_req = 1'b1; wr_en = 1'b1; wr_addr = 8'h03; wr_data = 8'hAA;
    cyc();
    check("rbw_data", 0, 32'(o_rd_data[0]), 32'h80);
    rd_req = 1'b0; wr_en = 1'b0;
    cyc(5);
    addr_load = 1'b1; addr_in = 8'h03;
    cyc();
    addr_load = 1'b0; rd_req = 1'b1;
    cyc();
    check("after_write", 0, 32'(o_rd_data[0]), 32'hAA);
    // A later write to the captured address must not reach the in-flight reads.
    rd_req = 1'b0; wr_en = 1'b1; wr_addr = 8'h03; wr_data = 8'h5C;
    cyc();
    wr_en = 1'b0;
    cyc(4);
    check("inflight_l4", 2, 32'(o_rd_data[2]), 32'hAA);
    check("inflight_l3", 1, 32'(o_rd_data[1]), 32'hAA);

    // Reset in the middle of a four-cycle read.
    addr_load = 1'b1; addr_in = 8'h01;
    cyc();
    addr_load = 1'b0; rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    cyc();
    check("pre_rst_busy", 2, 32'(o_busy[2]), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_mar", 2, 32'(o_mar[2]), 32'h0);
    check("rst_busy", 2, 32'(o_busy[2]), 32'h0);
    check("rst_valid", 2, 32'(o_rd_valid[2]), 32'h0);
    check("rst_data", 2, 32'(o_rd_data[2]), 32'h0);
    check("rst_addr", 2, 32'(o_rd_addr[2]), 32'h0);
    cyc();
    rst = 1'b0;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (o_rd_valid[2]) vcount++;
    end
    check("rst_abort", 2, 32'(vcount), 32'h0);

    // No auto-increment: repeated reads at the same MAR.
    addr_load = 1'b1; addr_in = 8'h01;
    cyc();
    addr_load = 1'b0; rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    cyc(2);
    check("noinc_valid1", 1, 32'(o_rd_valid[1]), 32'h1);
    check("noinc_data1", 1, 32'(o_rd_data[1]), 32'h04);
    cyc();
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    cyc(2);
    check("noinc_valid2", 1, 32'(o_rd_valid[1]), 32'h1);
    check("noinc_data2", 1, 32'(o_rd_data[1]), 32'h04);
    check("noinc_mar", 1, 32'(o_mar[1]), 32'h01);
    cyc(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
